// File: rtl/mr_fetch.sv
// In-order fetch stage: one outstanding imem read, allocates a retire slot
// in mr_wb per instruction and presents {inst, pc, id} to decode.
`ifndef IMAXLEN
`define IMAXLEN 16
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 4
`endif

module mr_fetch #(
  parameter int ADDR_W = `IMAXLEN,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int INST_W = 32,
  parameter int PC_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_W-1:0]       imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [INST_W-1:0]       imem_rsp_data,
  input  logic                    inst_buffer_full,
  input  logic [`INSTID_BITS-1:0] next_inst_id,
  output logic                    inst_in,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [INST_W-1:0]       dec_inst,
  output logic [ADDR_W-1:0]       dec_pc,
  output logic [`INSTID_BITS-1:0] dec_id
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_ALLOC,
    S_DRAIN
  } state_e;

  state_e                  state_q;
  logic [ADDR_W-1:0]       pc_q;
  logic [ADDR_W-1:0]       req_addr_q;
  logic                    squash_q;
  logic                    dec_valid_q;
  logic [INST_W-1:0]       dec_inst_q;
  logic [ADDR_W-1:0]       dec_pc_q;
  logic [`INSTID_BITS-1:0] dec_id_q;
  logic [ADDR_W-1:0]       pc_d;

  // pc as it will be after this cycle's redirect (last redirect wins)
  assign pc_d = redirect_valid ? redirect_pc : pc_q;

  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = req_addr_q;

  assign inst_in = (state_q == S_ALLOC) && !inst_buffer_full &&
                   !redirect_valid && !rst;
  assign inst_pc = pc_q;

  assign dec_valid = dec_valid_q;
  assign dec_inst  = dec_inst_q;
  assign dec_pc    = dec_pc_q;
  assign dec_id    = dec_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      squash_q    <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      if (redirect_valid) pc_q <= redirect_pc;
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_q <= S_WAIT;
            if (redirect_valid) squash_q <= 1'b1;
          end else if (redirect_valid) begin
            req_addr_q <= redirect_pc;
          end
        end
        S_WAIT: begin
          if (redirect_valid) squash_q <= 1'b1;
          if (imem_rsp_valid) begin
            dec_inst_q <= imem_rsp_data;
            if (squash_q || redirect_valid) begin
              squash_q   <= 1'b0;
              req_addr_q <= pc_d;
              state_q    <= S_REQ;
            end else begin
              state_q <= S_ALLOC;
            end
          end
        end
        S_ALLOC: begin
          if (redirect_valid) begin
            req_addr_q <= redirect_pc;
            state_q    <= S_REQ;
          end else if (!inst_buffer_full) begin
            dec_id_q    <= next_inst_id;
            dec_pc_q    <= pc_q;
            dec_valid_q <= 1'b1;
            pc_q        <= pc_q + ADDR_W'(PC_STEP);
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // already allocated: a redirect here only retargets the next fetch
          if (dec_ready) begin
            dec_valid_q <= 1'b0;
            req_addr_q  <= pc_d;
            state_q     <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule
